// File: rtl/rv32_wb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rv32_wb_pkg : shared writeback entry type and default geometry       |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
package rv32_wb_pkg;

  localparam int NUM_SRC_DEF = 4;
  localparam int DEPTH_DEF   = 2;
  localparam int XLEN_DEF    = 32;

  typedef struct packed {
    logic [4:0]          rd;
    logic                fp;
    logic [XLEN_DEF-1:0] data;
    logic [31:0]         instr;
  } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/rv32_wb_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rv32_wb_fifo : per-source result buffer, extra pointer bit for full  |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
module rv32_wb_fifo
  import rv32_wb_pkg::*;
#(
  parameter int  DEPTH = DEPTH_DEF,
  parameter type T     = wb_entry_t
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic flush_i,
  input  logic push_i,
  input  logic pop_i,
  input  T     data_i,
  output T     data_o,
  output logic full_o,
  output logic empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        w_push;
  logic        w_pop;
  T            mem_q [DEPTH];

  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  // full_o comes from registered pointers only, so a pop never frees a slot in the same cycle
  assign w_push  = push_i && !full_o && !flush_i;
  assign w_pop   = pop_i && !empty_o && !flush_i;
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (w_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (w_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule
`default_nettype wire

// File: rtl/rv32_writeback_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rv32_writeback_arbiter : buffered round-robin register-file writeback|
// | Revision               : 1.0                                         |
// +----------------------------------------------------------------------+
module rv32_writeback_arbiter
  import rv32_wb_pkg::*;
#(
  parameter int NUM_SRC = NUM_SRC_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int XLEN    = XLEN_DEF
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            flush_i,
  input  logic [NUM_SRC-1:0]              src_valid_i,
  output logic [NUM_SRC-1:0]              src_ready_o,
  input  logic [NUM_SRC-1:0][4:0]         src_rd_i,
  input  logic [NUM_SRC-1:0]              src_fp_i,
  input  logic [NUM_SRC-1:0][XLEN-1:0]    src_data_i,
  input  logic [NUM_SRC-1:0][31:0]        src_instr_i,
  output logic                            wb_valid_o,
  output logic [4:0]                      wb_rd_o,
  output logic                            wb_fp_o,
  output logic [XLEN-1:0]                 wb_data_o,
  output logic [31:0]                     wb_instr_o,
  output logic [$clog2(NUM_SRC)-1:0]      wb_src_o
);

  localparam int SW = $clog2(NUM_SRC);

  // Same layout as wb_entry_t but sized by this instance's XLEN
  typedef struct packed {
    logic [4:0]      rd;
    logic            fp;
    logic [XLEN-1:0] data;
    logic [31:0]     instr;
  } entry_t;

  entry_t               w_din  [NUM_SRC];
  entry_t               w_dout [NUM_SRC];
  entry_t               w_sel;
  logic [NUM_SRC-1:0]   w_full;
  logic [NUM_SRC-1:0]   w_empty;
  logic [NUM_SRC-1:0]   w_pop;
  logic                 w_gnt;
  logic [SW-1:0]        w_gnt_idx;
  logic [SW-1:0]        w_cand;

  logic [SW-1:0]        rr_ptr_q, rr_ptr_d;
  logic                 wb_valid_q;
  entry_t               wb_q;
  logic [SW-1:0]        wb_src_q;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign w_din[i] = '{rd: src_rd_i[i], fp: src_fp_i[i], data: src_data_i[i], instr: src_instr_i[i]};

    rv32_wb_fifo #(
      .DEPTH (DEPTH),
      .T     (entry_t)
    ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .flush_i (flush_i),
      .push_i  (src_valid_i[i]),
      .pop_i   (w_pop[i]),
      .data_i  (w_din[i]),
      .data_o  (w_dout[i]),
      .full_o  (w_full[i]),
      .empty_o (w_empty[i])
    );

    assign src_ready_o[i] = ~w_full[i];
    assign w_pop[i]       = w_gnt && (w_gnt_idx == SW'(i));
  end

  // rr_ptr_q holds the first index to search, i.e. last grant + 1
  always_comb begin
    w_gnt     = 1'b0;
    w_gnt_idx = '0;
    w_cand    = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      w_cand = SW'((int'(rr_ptr_q) + k) % NUM_SRC);
      if (!w_gnt && !w_empty[w_cand]) begin
        w_gnt     = 1'b1;
        w_gnt_idx = w_cand;
      end
    end
    if (flush_i) w_gnt = 1'b0;
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (w_gnt) rr_ptr_d = SW'((int'(w_gnt_idx) + 1) % NUM_SRC);
  end

  assign w_sel = w_dout[w_gnt_idx];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q   <= '0;
      wb_valid_q <= 1'b0;
      wb_q       <= '0;
      wb_src_q   <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      // x0 integer writes drain from the buffer but never reach the register file
      wb_valid_q <= w_gnt && (w_sel.fp || (w_sel.rd != 5'd0));
      if (w_gnt) begin
        wb_q     <= w_sel;
        wb_src_q <= w_gnt_idx;
      end
    end
  end

  assign wb_valid_o = wb_valid_q;
  assign wb_rd_o    = wb_q.rd;
  assign wb_fp_o    = wb_q.fp;
  assign wb_data_o  = wb_q.data;
  assign wb_instr_o = wb_q.instr;
  assign wb_src_o   = wb_src_q;

endmodule
`default_nettype wire

// File: tb/tb_rv32_writeback_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_rv32_writeback_arbiter : scoreboard bench for writeback arbiter   |
// | Revision                  : 1.0                                      |
// +----------------------------------------------------------------------+
module tb_rv32_writeback_arbiter;

  typedef struct packed {
    logic [4:0]  rd;
    logic        fp;
    logic [31:0] data;
    logic [31:0] instr;
  } exp_t;

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b0;
  logic             flush_i = 1'b0;
  logic [3:0]       src_valid_i = '0;
  logic [3:0]       src_ready_o;
  logic [3:0][4:0]  src_rd_i = '0;
  logic [3:0]       src_fp_i = '0;
  logic [3:0][31:0] src_data_i = '0;
  logic [3:0][31:0] src_instr_i = '0;
  logic             wb_valid_o;
  logic [4:0]       wb_rd_o;
  logic             wb_fp_o;
  logic [31:0]      wb_data_o;
  logic [31:0]      wb_instr_o;
  logic [1:0]       wb_src_o;

  int   checks = 0;
  int   errors = 0;
  int   wb_count = 0;
  logic last_fp = 1'b0;
  exp_t exp_q [4][$];

  rv32_writeback_arbiter #(.NUM_SRC(4), .DEPTH(2), .XLEN(32)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (flush_i),
    .src_valid_i (src_valid_i),
    .src_ready_o (src_ready_o),
    .src_rd_i    (src_rd_i),
    .src_fp_i    (src_fp_i),
    .src_data_i  (src_data_i),
    .src_instr_i (src_instr_i),
    .wb_valid_o  (wb_valid_o),
    .wb_rd_o     (wb_rd_o),
    .wb_fp_o     (wb_fp_o),
    .wb_data_o   (wb_data_o),
    .wb_instr_o  (wb_instr_o),
    .wb_src_o    (wb_src_o)
  );

  always #5 clk_i = ~clk_i;

  // Every writeback must match the oldest outstanding entry of its source
  always @(negedge clk_i) begin
    if (rst_ni && wb_valid_o) begin
      exp_t e;
      checks++;
      wb_count++;
      last_fp = wb_fp_o;
      if (exp_q[wb_src_o].size() == 0) begin
        errors++;
        $display("FAIL unexpected_wb: src=%0d rd=%0d data=%h, required no writeback", wb_src_o, wb_rd_o, wb_data_o);
      end else begin
        e = exp_q[wb_src_o].pop_front();
        if ({wb_rd_o, wb_fp_o, wb_data_o, wb_instr_o} !== e) begin
          errors++;
          $display("FAIL wb_entry: src=%0d got rd=%0d fp=%b data=%h instr=%h, required rd=%0d fp=%b data=%h instr=%h",
                   wb_src_o, wb_rd_o, wb_fp_o, wb_data_o, wb_instr_o, e.rd, e.fp, e.data, e.instr);
        end
      end
    end
  end

  task automatic clear_model();
    for (int i = 0; i < 4; i++) exp_q[i].delete();
  endtask

  task automatic set_src(input int i, input logic [4:0] rd, input logic fp, input logic [31:0] data);
    src_valid_i[i] = 1'b1;
    src_rd_i[i]    = rd;
    src_fp_i[i]    = fp;
    src_data_i[i]  = data;
    src_instr_i[i] = data ^ 32'h0000_0013;
  endtask

  // Called at posedge+1; records accepted pushes, then advances one clock
  task automatic step();
    logic fl;
    fl = flush_i;
    for (int i = 0; i < 4; i++) begin
      if (src_valid_i[i] && src_ready_o[i] && !fl && (src_fp_i[i] || src_rd_i[i] != 5'd0))
        exp_q[i].push_back({src_rd_i[i], src_fp_i[i], src_data_i[i], src_instr_i[i]});
    end
    @(posedge clk_i);
    #1;
    src_valid_i = '0;
    flush_i     = 1'b0;
    if (fl) clear_model();
  endtask

  task automatic do_reset();
    @(posedge clk_i);
    #1;
    rst_ni = 1'b0;
    clear_model();
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({wb_valid_o, wb_rd_o, wb_fp_o, wb_data_o, wb_instr_o, wb_src_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b rd=%0d data=%h src=%0d, required all zero", wb_valid_o, wb_rd_o, wb_data_o, wb_src_o);
    end
    checks++;
    if (src_ready_o !== 4'hF) begin
      errors++;
      $display("FAIL reset_ready: got %b, required 1111", src_ready_o);
    end
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  task automatic test_single();
    set_src(0, 5'd5, 1'b0, 32'hDEAD_BEEF);
    step();
    @(negedge clk_i);
    checks++;
    if (wb_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL single_early: wb_valid=%b, required 0", wb_valid_o);
    end
    @(negedge clk_i);
    checks++;
    if ({wb_valid_o, wb_rd_o, wb_data_o, wb_src_o} !== {1'b1, 5'd5, 32'hDEAD_BEEF, 2'd0}) begin
      errors++;
      $display("FAIL single_wb: valid=%b rd=%0d data=%h src=%0d, required 1 5 deadbeef 0", wb_valid_o, wb_rd_o, wb_data_o, wb_src_o);
    end
    @(negedge clk_i);
    checks++;
    if (wb_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL single_late: wb_valid=%b, required 0", wb_valid_o);
    end
  endtask

  task automatic test_all_sources();
    do_reset();
    for (int i = 0; i < 4; i++) set_src(i, 5'(i + 10), 1'b0, 32'h1000_0000 + i);
    step();
    @(negedge clk_i);
    checks++;
    if (wb_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL rr_first_cycle: wb_valid=%b, required 0", wb_valid_o);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      checks++;
      if ({wb_valid_o, wb_src_o} !== {1'b1, 2'(k)}) begin
        errors++;
        $display("FAIL rr_order: cycle %0d valid=%b src=%0d, required 1 %0d", k + 2, wb_valid_o, wb_src_o, k);
      end
    end
    @(negedge clk_i);
    checks++;
    if (wb_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL rr_idle: wb_valid=%b, required 0", wb_valid_o);
    end
  endtask

  task automatic test_back_to_back();
    wb_count = 0;
    for (int k = 0; k < 3; k++) begin
      set_src(2, 5'(k + 20), 1'b0, 32'h2000_0000 + k);
      step();
    end
    repeat (5) @(posedge clk_i);
    #1;
    checks++;
    if (wb_count != 3) begin
      errors++;
      $display("FAIL b2b_count: got %0d writebacks, required 3", wb_count);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (exp_q[i].size() != 0) begin
        errors++;
        $display("FAIL b2b_drain: src %0d has %0d pending, required 0", i, exp_q[i].size());
      end
    end
  endtask

  task automatic test_rd_zero();
    wb_count = 0;
    set_src(1, 5'd0, 1'b0, 32'h3333_0001);
    set_src(3, 5'd0, 1'b1, 32'h3333_0003);
    step();
    repeat (4) @(posedge clk_i);
    #1;
    checks++;
    if ({wb_count, last_fp} !== {32'd1, 1'b1}) begin
      errors++;
      $display("FAIL rd_zero: got %0d writes last_fp=%b, required 1 write with fp=1", wb_count, last_fp);
    end
  endtask

  task automatic test_full_flush();
    do_reset();
    for (int i = 0; i < 4; i++) set_src(i, 5'(i + 1), 1'b0, 32'hA000_0000 + i);
    step();
    checks++;
    if (src_ready_o !== 4'b1111) begin
      errors++;
      $display("FAIL full_ready0: got %b, required 1111", src_ready_o);
    end
    for (int i = 0; i < 4; i++) set_src(i, 5'(i + 1), 1'b0, 32'hB000_0000 + i);
    step();
    checks++;
    if (src_ready_o !== 4'b0001) begin
      errors++;
      $display("FAIL full_ready1: got %b, required 0001", src_ready_o);
    end
    for (int i = 0; i < 4; i++) set_src(i, 5'(i + 1), 1'b0, 32'hC000_0000 + i);
    step();
    checks++;
    if (src_ready_o !== 4'b0010) begin
      errors++;
      $display("FAIL full_ready2: got %b, required 0010", src_ready_o);
    end
    flush_i = 1'b1;
    set_src(1, 5'd9, 1'b0, 32'hD000_0001);
    step();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      checks++;
      if ({wb_valid_o, src_ready_o} !== {1'b0, 4'hF}) begin
        errors++;
        $display("FAIL flush_state: cycle %0d valid=%b ready=%b, required 0 1111", k, wb_valid_o, src_ready_o);
      end
    end
    @(posedge clk_i);
    #1;
    for (int i = 0; i < 4; i++) set_src(i, 5'(i + 1), 1'b1, 32'hE000_0000 + i);
    step();
    @(negedge clk_i);
    @(negedge clk_i);
    checks++;
    if ({wb_valid_o, wb_src_o} !== {1'b1, 2'd2}) begin
      errors++;
      $display("FAIL flush_rr_kept: valid=%b src=%0d, required 1 2", wb_valid_o, wb_src_o);
    end
    repeat (5) @(posedge clk_i);
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (exp_q[i].size() != 0) begin
        errors++;
        $display("FAIL flush_drain: src %0d has %0d pending, required 0", i, exp_q[i].size());
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) set_src(i, 5'(i + 1), 1'b0, 32'hF000_0000 + 32'(k * 4 + i));
      step();
    end
    checks++;
    if (wb_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL areset_pre: wb_valid=%b, required 1", wb_valid_o);
    end
    #2;
    rst_ni = 1'b0;
    #1;
    clear_model();
    checks++;
    if ({wb_valid_o, wb_rd_o, wb_fp_o, wb_data_o, wb_instr_o, wb_src_o, src_ready_o} !== {73'd0, 4'hF}) begin
      errors++;
      $display("FAIL areset_now: valid=%b rd=%0d data=%h src=%0d ready=%b, required zeros and ready 1111",
               wb_valid_o, wb_rd_o, wb_data_o, wb_src_o, src_ready_o);
    end
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    wb_count = 0;
    repeat (6) @(posedge clk_i);
    #1;
    checks++;
    if (wb_count != 0) begin
      errors++;
      $display("FAIL areset_stale: got %0d writebacks after release, required 0", wb_count);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_sources();
    test_back_to_back();
    test_rd_zero();
    test_full_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
